fp_mult_iter: RTL and testbench

Area-optimised, iterative IEEE-754 floating-point multiplier. Uses a shift-add mantissa datapath that consumes radix_bits multiplier bits per cycle, instead of a full array multiplier.
Uses a valid/ready handshake on input and output, carries a user tag, and takes a per-operation rounding mode.
Special operands (zero/denormal, Inf, NaN) bypass the iteration.
Sits beside the combinational/pipelined fp_mult in the FP component library. Intended for low-area datapaths that can tolerate multi-cycle latency.

---
 rtl/enum_typedefs_pkg.sv | 37 +++
 rtl/mant_mult_iter.sv | 60 ++++++
 rtl/fp_mult_iter.sv | 212 +++++++++++++++++++++
 tb/tb_fp_mult_iter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enum_typedefs_pkg.sv
// Shared FP component types: rounding modes, iterative-multiplier states,
// status bit positions and the canonical quiet NaN pattern.
package enum_typedefs_pkg;

  typedef enum logic [2:0] {
    RND_RNE = 3'd0,
    RND_RTZ = 3'd1,
    RND_RUP = 3'd2,
    RND_RDN = 3'd3,
    RND_RNA = 3'd4,
    RND_RAW = 3'd5
  } round_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_RND,
    S_DONE
  } fp_mult_state_t;

  localparam int unsigned STAT_ZERO    = 0;
  localparam int unsigned STAT_INF     = 1;
  localparam int unsigned STAT_NAN     = 2;
  localparam int unsigned STAT_TINY    = 3;
  localparam int unsigned STAT_HUGE    = 4;
  localparam int unsigned STAT_INEXACT = 5;

  // {0, all-ones exponent, fraction MSB set}; caller slices the low bits it needs.
  function automatic logic [63:0] fp_canonical_nan(input int unsigned sw, input int unsigned ew);
    logic [63:0] v;
    v = '0;
    v[sw-1] = 1'b1;
    for (int unsigned i = 0; i < ew; i++) v[sw+i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mant_mult_iter.sv
// Shift-add mantissa multiplier retiring radix_bits multiplier bits per cycle.
// The accumulator shifts right each cycle so only a width+radix_bits adder is needed.
module mant_mult_iter
  import enum_typedefs_pkg::*;
#(
  parameter int unsigned width      = 24,
  parameter int unsigned radix_bits = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [width-1:0]     in1,
  input  logic [width-1:0]     in2,
  output logic                 busy,
  output logic                 done,
  output logic [2*width-1:0]   res
);
  localparam int unsigned N  = (width + radix_bits - 1) / radix_bits;
  localparam int unsigned BW = N * radix_bits;
  localparam int unsigned AW = width + BW;
  localparam int unsigned CW = $clog2(N + 1);

  logic [width-1:0]            r_ma;
  logic [BW-1:0]               r_mb;
  logic [AW-1:0]               r_acc;
  logic [CW-1:0]               r_cnt;
  logic                        r_busy;
  logic [width+radix_bits-1:0] w_part;
  logic [width+radix_bits-1:0] w_sum;

  assign w_part = {{radix_bits{1'b0}}, r_ma} * {{width{1'b0}}, r_mb[radix_bits-1:0]};
  assign w_sum  = {{radix_bits{1'b0}}, r_acc[AW-1:BW]} + w_part;

  assign busy = r_busy;
  assign done = r_busy && (r_cnt == CW'(N - 1));
  assign res  = r_acc[2*width-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ma   <= '0;
      r_mb   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_ma   <= in1;
      r_mb   <= BW'(in2);
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      // new partial sum lands in the top; retired low bits slide down
      r_acc <= {w_sum, r_acc[BW-1:radix_bits]};
      r_mb  <= r_mb >> radix_bits;
      r_cnt <= r_cnt + 1'b1;
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_mult_iter.sv
// Iterative IEEE-754 multiplier: valid/ready in and out, tag pass-through,
// per-operation rounding mode; special operands skip the mantissa iteration.
module fp_mult_iter
  import enum_typedefs_pkg::*;
#(
  parameter int unsigned sig_width  = 23,
  parameter int unsigned ex_width   = 8,
  parameter int unsigned radix_bits = 2,
  parameter int unsigned tag_width  = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [sig_width+ex_width:0]   a,
  input  logic [sig_width+ex_width:0]   b,
  input  logic [2:0]                    round,
  input  logic [tag_width-1:0]          tag_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [sig_width+ex_width:0]   z,
  output logic [7:0]                    status,
  output logic [tag_width-1:0]          tag_out
);
  localparam int unsigned W   = sig_width + ex_width + 1;
  localparam int unsigned MW  = sig_width + 1;
  localparam int unsigned PW  = 2 * MW;
  localparam int unsigned EW2 = ex_width + 2;
  localparam logic [EW2-1:0]        BIAS  = EW2'((2 ** (ex_width - 1)) - 1);
  localparam logic signed [EW2-1:0] EMAX  = {2'b00, {ex_width{1'b1}}};
  localparam logic [63:0]           NAN64 = fp_canonical_nan(sig_width, ex_width);
  localparam logic [W-1:0]          QNAN  = NAN64[W-1:0];

  fp_mult_state_t r_state, w_next;

  logic [ex_width-1:0]  w_ea, w_eb;
  logic [sig_width-1:0] w_fa, w_fb;
  logic w_a_zero, w_b_zero, w_a_emax, w_b_emax;
  logic w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic w_in_special, w_sp_nan, w_sp_inf, w_accept, w_mm_start;
  logic [EW2-1:0] w_exp_sum;

  logic                   r_sign, r_special, r_sp_nan, r_sp_inf;
  logic signed [EW2-1:0]  r_exp;
  logic [2:0]             r_round;
  logic [tag_width-1:0]   r_tag;
  logic [W-1:0]           r_z;
  logic [7:0]             r_status;
  logic [tag_width-1:0]   r_tag_out;

  logic                   w_mm_busy, w_mm_done;
  logic [PW-1:0]          w_prod;
  logic                   w_msb, w_guard, w_sticky, w_inc, w_carry, w_ovf_inf;
  logic [sig_width-1:0]   w_frac;
  logic [sig_width:0]     w_frac_r;
  logic signed [EW2-1:0]  w_exp_f;
  logic                   w_ovf, w_unf;
  logic [W-1:0]           w_z;
  logic [7:0]             w_st;

  assign w_ea = a[W-2 -: ex_width];
  assign w_eb = b[W-2 -: ex_width];
  assign w_fa = a[sig_width-1:0];
  assign w_fb = b[sig_width-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_emax = &w_ea;
  assign w_b_emax = &w_eb;
  assign w_a_nan  = w_a_emax & (|w_fa);
  assign w_b_nan  = w_b_emax & (|w_fb);
  assign w_a_inf  = w_a_emax & ~(|w_fa);
  assign w_b_inf  = w_b_emax & ~(|w_fb);
  assign w_in_special = w_a_zero | w_b_zero | w_a_emax | w_b_emax;
  assign w_sp_nan = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf);
  assign w_sp_inf = w_a_inf | w_b_inf;
  assign w_exp_sum = {2'b00, w_ea} + {2'b00, w_eb} - BIAS;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign w_accept   = in_valid & in_ready;
  assign w_mm_start = w_accept & ~w_in_special;

  mant_mult_iter #(.width(MW), .radix_bits(radix_bits)) u_mant (
    .clk    (clk),
    .resetn (resetn),
    .start  (w_mm_start),
    .in1    ({1'b1, w_fa}),
    .in2    ({1'b1, w_fb}),
    .busy   (w_mm_busy),
    .done   (w_mm_done),
    .res    (w_prod)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = w_in_special ? S_RND : S_MULT;
      S_MULT: if (w_mm_done || !w_mm_busy) w_next = S_RND;
      S_RND:  w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Product lies in [1,4): pick the fraction window according to the MSB.
  assign w_msb = w_prod[PW-1];

  always_comb begin
    if (w_msb) begin
      w_frac   = w_prod[PW-2 -: sig_width];
      w_guard  = w_prod[sig_width];
      w_sticky = |w_prod[sig_width-1:0];
    end else begin
      w_frac   = w_prod[PW-3 -: sig_width];
      w_guard  = w_prod[sig_width-1];
      w_sticky = |w_prod[sig_width-2:0];
    end
  end

  always_comb begin
    w_inc     = 1'b0;
    w_ovf_inf = 1'b1;
    case (r_round)
      RND_RTZ: begin w_inc = 1'b0;                           w_ovf_inf = 1'b0;    end
      RND_RUP: begin w_inc = (w_guard | w_sticky) & ~r_sign; w_ovf_inf = ~r_sign; end
      RND_RDN: begin w_inc = (w_guard | w_sticky) & r_sign;  w_ovf_inf = r_sign;  end
      RND_RNA: w_inc = w_guard;
      RND_RAW: w_inc = w_guard | w_sticky;
      default: w_inc = w_guard & (w_sticky | w_frac[0]);
    endcase
  end

  assign w_frac_r = {1'b0, w_frac} + {{sig_width{1'b0}}, w_inc};
  assign w_carry  = w_frac_r[sig_width];
  assign w_exp_f  = r_exp + EW2'(w_msb) + EW2'(w_carry);
  assign w_ovf    = (w_exp_f >= EMAX);
  assign w_unf    = w_exp_f[EW2-1] || (w_exp_f == '0);

  always_comb begin
    w_z  = '0;
    w_st = '0;
    if (r_special) begin
      if (r_sp_nan) begin
        w_z = QNAN;
        w_st[STAT_NAN] = 1'b1;
      end else if (r_sp_inf) begin
        w_z = {r_sign, {ex_width{1'b1}}, {sig_width{1'b0}}};
        w_st[STAT_INF] = 1'b1;
      end else begin
        w_z = {r_sign, {(W-1){1'b0}}};
        w_st[STAT_ZERO] = 1'b1;
      end
    end else if (w_ovf) begin
      w_st[STAT_HUGE]    = 1'b1;
      w_st[STAT_INEXACT] = 1'b1;
      if (w_ovf_inf) begin
        w_z = {r_sign, {ex_width{1'b1}}, {sig_width{1'b0}}};
        w_st[STAT_INF] = 1'b1;
      end else begin
        w_z = {r_sign, {(ex_width-1){1'b1}}, 1'b0, {sig_width{1'b1}}};
      end
    end else if (w_unf) begin
      w_z = {r_sign, {(W-1){1'b0}}};
      w_st[STAT_TINY]    = 1'b1;
      w_st[STAT_ZERO]    = 1'b1;
      w_st[STAT_INEXACT] = 1'b1;
    end else begin
      w_z = {r_sign, w_exp_f[ex_width-1:0], w_frac_r[sig_width-1:0]};
      w_st[STAT_INEXACT] = w_guard | w_sticky;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sign    <= 1'b0;
      r_special <= 1'b0;
      r_sp_nan  <= 1'b0;
      r_sp_inf  <= 1'b0;
      r_exp     <= '0;
      r_round   <= '0;
      r_tag     <= '0;
      r_z       <= '0;
      r_status  <= '0;
      r_tag_out <= '0;
    end else begin
      if (w_accept) begin
        r_sign    <= a[W-1] ^ b[W-1];
        r_special <= w_in_special;
        r_sp_nan  <= w_sp_nan;
        r_sp_inf  <= w_sp_inf;
        r_exp     <= w_exp_sum;
        r_round   <= round;
        r_tag     <= tag_in;
      end
      if (r_state == S_RND) begin
        r_z       <= w_z;
        r_status  <= w_st;
        r_tag_out <= r_tag;
      end
    end
  end

  assign z       = r_z;
  assign status  = r_status;
  assign tag_out = r_tag_out;

endmodule

// File: tb/tb_fp_mult_iter.sv
// Directed bench for fp_mult_iter: reference model of binary32 multiplication,
// per-cycle output comparison, plus literal expectations for each vector.
module tb_fp_mult_iter;
  logic clk = 1'b0, resetn = 1'b0;
  logic in_valid = 1'b0, iv1 = 1'b0, iv4 = 1'b0;
  logic out_ready = 1'b0, or1 = 1'b0, or4 = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [2:0]  round = '0;
  logic [3:0]  tag_in = '0;
  logic        in_ready, out_valid, ir1, ov1, ir4, ov4;
  logic [31:0] z, z1, z4;
  logic [7:0]  status, st1, st4;
  logic [3:0]  tag_out, tg1, tg4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_mult_iter #(.sig_width(23), .ex_width(8), .radix_bits(2), .tag_width(4)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .round(round), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .status(status), .tag_out(tag_out));

  fp_mult_iter #(.sig_width(23), .ex_width(8), .radix_bits(1), .tag_width(4)) dut1 (
    .clk(clk), .resetn(resetn), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
    .round(round), .tag_in(tag_in), .out_valid(ov1), .out_ready(or1),
    .z(z1), .status(st1), .tag_out(tg1));

  fp_mult_iter #(.sig_width(23), .ex_width(8), .radix_bits(4), .tag_width(4)) dut4 (
    .clk(clk), .resetn(resetn), .in_valid(iv4), .in_ready(ir4), .a(a), .b(b),
    .round(round), .tag_in(tag_in), .out_valid(ov4), .out_ready(or4),
    .z(z4), .status(st4), .tag_out(tg4));

  typedef struct { logic [31:0] z; logic [7:0] st; logic [3:0] tg; } exp_t;
  typedef struct { logic [31:0] a, b; logic [2:0] rm; logic [31:0] z; logic [7:0] st; int lat; } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact integer product, rounded by comparing the discarded remainder to one half.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic [2:0] rm, input logic [3:0] tg);
    exp_t r;
    bit s, up, xz, yz, xi, yi, xn, yn;
    int ex, ey, e, k;
    longint p, q, rem, half;
    r.tg = tg;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);  yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);  yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);  yn = (ey == 255) && (y[22:0] != 0);
    if (xn || yn || (xi && yz) || (xz && yi)) begin r.z = 32'h7FC00000; r.st = 8'h04; return r; end
    if (xi || yi) begin r.z = {s, 8'hFF, 23'h0}; r.st = 8'h02; return r; end
    if (xz || yz) begin r.z = {s, 31'h0}; r.st = 8'h01; return r; end
    p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
    e = ex + ey - 127;
    if (p >= (longint'(1) << 47)) begin k = 24; e++; end
    else k = 23;
    q    = p >> k;
    rem  = p - (q << k);
    half = longint'(1) << (k - 1);
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = !s && (rem != 0);
      3'd3:    up = s && (rem != 0);
      3'd4:    up = (rem >= half);
      3'd5:    up = (rem != 0);
      default: up = (rem > half) || ((rem == half) && q[0]);
    endcase
    q = q + longint'(up);
    if (q == (longint'(1) << 24)) begin q = q >> 1; e++; end
    if (e >= 255) begin
      if (rm == 3'd1 || (rm == 3'd2 && s) || (rm == 3'd3 && !s)) begin
        r.z = {s, 8'hFE, 23'h7FFFFF}; r.st = 8'h30;
      end else begin
        r.z = {s, 8'hFF, 23'h0}; r.st = 8'h32;
      end
    end else if (e <= 0) begin
      r.z = {s, 31'h0}; r.st = 8'h29;
    end else begin
      r.z  = {s, 8'(e), q[22:0]};
      r.st = (rem != 0) ? 8'h20 : 8'h00;
    end
    return r;
  endfunction

  exp_t q_exp[$];
  exp_t cur;
  bit   have_cur = 1'b0;

  always @(posedge clk) begin
    if (resetn && in_valid && in_ready) q_exp.push_back(model(a, b, round, tag_in));
  end

  always @(negedge clk) begin
    if (!resetn) begin
      q_exp.delete();
      have_cur = 1'b0;
    end else if (out_valid) begin
      if (!have_cur) begin
        if (q_exp.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL mon_unexpected: got out_valid=1 with no pending op, required none");
        end else begin
          cur = q_exp.pop_front();
          have_cur = 1'b1;
        end
      end
      if (have_cur) begin
        chk("mon_z", z, cur.z);
        chk("mon_status", status, cur.st);
        chk("mon_tag", tag_out, cur.tg);
      end
      if (out_ready) have_cur = 1'b0;
    end
  end

  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] rm,
                       input logic [3:0] tg, output int lat, output bit ready_low);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    a = ia; b = ib; round = rm; tag_in = tg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; round = 3'($urandom); tag_in = 4'($urandom);
    lat = 0; ready_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_low = 1'b0;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic aux_op(input bit four, output int lat);
    a = 32'h3FC00000; b = 32'h40000000; round = 3'd0; tag_in = 4'd5;
    if (four) iv4 = 1'b1; else iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv4 = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    while (!(four ? ov4 : ov1) && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  vec_t vt[$];

  initial begin
    int lat, cnt;
    bit rl;
    vt = '{
      '{32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 8'h20, 13},
      '{32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800003, 8'h20, 13},
      '{32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 8'h20, 13},
      '{32'h3F800001, 32'h3F800001, 3'd4, 32'h3F800002, 8'h20, 13},
      '{32'h3F800001, 32'h3F800001, 3'd5, 32'h3F800003, 8'h20, 13},
      '{32'h3F800001, 32'h3F800001, 3'd7, 32'h3F800002, 8'h20, 13},
      '{32'hBF800001, 32'h3F800001, 3'd3, 32'hBF800003, 8'h20, 13},
      '{32'hBF800001, 32'h3F800001, 3'd2, 32'hBF800002, 8'h20, 13},
      '{32'h3FC00006, 32'h3FC00000, 3'd0, 32'h40100004, 8'h20, 13},
      '{32'h3FC00006, 32'h3FC00000, 3'd4, 32'h40100005, 8'h20, 13},
      '{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 8'h04, 1},
      '{32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 8'h02, 1},
      '{32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 8'h04, 1},
      '{32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 8'h01, 1},
      '{32'h7F000000, 32'h7F000000, 3'd0, 32'h7F800000, 8'h32, 13},
      '{32'h7F000000, 32'h7F000000, 3'd1, 32'h7F7FFFFF, 8'h30, 13},
      '{32'h7F000000, 32'h7F000000, 3'd3, 32'h7F7FFFFF, 8'h30, 13},
      '{32'hFF000000, 32'h7F000000, 3'd3, 32'hFF800000, 8'h32, 13},
      '{32'h00800000, 32'h00800000, 3'd0, 32'h00000000, 8'h29, 13}
    };

    #12;
    chk("rst_z", z, 0);
    chk("rst_status", status, 0);
    chk("rst_tag", tag_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 resetn = 1'b1;

    do_op(32'h3FC00000, 32'h40000000, 3'd0, 4'd5, lat, rl);
    chk("basic_lat", lat, 13);
    chk("basic_z", z, 32'h40400000);
    chk("basic_status", status, 8'h00);
    chk("basic_tag", tag_out, 4'd5);
    chk("basic_ready_low", rl, 1);
    release_out();

    foreach (vt[i]) begin
      do_op(vt[i].a, vt[i].b, vt[i].rm, 4'(i), lat, rl);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_z", i), z, vt[i].z);
      chk($sformatf("vec%0d_status", i), status, vt[i].st);
      release_out();
    end

    do_op(32'h40400000, 32'h40400000, 3'd0, 4'd9, lat, rl);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_z", z, 32'h41100000);
      chk("bp_status", status, 8'h00);
      chk("bp_tag", tag_out, 4'd9);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    do_op(32'hBF800000, 32'h3F800000, 3'd3, 4'hA, lat, rl);
    chk("b2b_lat", lat, 13);
    chk("b2b_z", z, 32'hBF800000);
    chk("b2b_status", status, 8'h00);
    chk("b2b_tag", tag_out, 4'hA);
    release_out();

    a = 32'h3FC00000; b = 32'h40000000; round = 3'd0; tag_in = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_z", z, 0);
    chk("mrst_status", status, 0);
    chk("mrst_tag", tag_out, 0);
    @(posedge clk); #1 resetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("mrst_no_stale", cnt, 0);
    do_op(32'h3FC00000, 32'h40000000, 3'd0, 4'd6, lat, rl);
    chk("post_rst_lat", lat, 13);
    chk("post_rst_z", z, 32'h40400000);
    release_out();

    aux_op(1'b0, lat);
    chk("r1_lat", lat, 25);
    chk("r1_z", z1, 32'h40400000);
    chk("r1_status", st1, 8'h00);
    chk("r1_tag", tg1, 4'd5);
    aux_op(1'b1, lat);
    chk("r4_lat", lat, 7);
    chk("r4_z", z4, 32'h40400000);
    chk("r4_status", st4, 8'h00);
    chk("r4_tag", tg4, 4'd5);

    repeat (3) @(posedge clk);
    chk("queue_drained", q_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion by 200000, required completion");
    $fatal(1);
  end

endmodule
